// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: request opcodes and
// controller state encoding, plus a small opcode classifier.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // True for the ops that occupy the shared datapath for WIDTH+1 cycles.
  function automatic logic is_multi(input muldiv_op_t o);
    return (o == MD_MULT) || (o == MD_MULTU) || (o == MD_DIV) || (o == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iteration datapath: 2*WIDTH accumulator, latched operand and step counter.
// Multiply is shift-add (LSB first); divide is restoring, one quotient bit per step.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd_q;
  logic               div_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;

  // op_a always goes into the low half: multiplier for MUL, dividend for DIV.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      acc_q  <= {{WIDTH{1'b0}}, op_a};
      opnd_q <= op_b;
      div_q  <= is_div;
      cnt_q  <= '0;
    end else if (step) begin
      acc_q  <= acc_nxt;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    diff    = {1'b0, rem_sh} - {2'b00, opnd_q};
    acc_nxt = acc_q;
    if (div_q) begin
      if (!diff[WIDTH+1])
        acc_nxt = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide controller: FSM, operand sign handling, HI/LO ownership.
// Handshake: start is a request, taken only in a cycle where busy=0 and flush=0.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output md_state_t        dbg_state
);

  md_state_t state_q, state_d;

  logic               accept;
  logic               mt_wr;
  logic               signed_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               core_last;
  logic [2*WIDTH-1:0] core_acc;

  logic               div_q;
  logic               neg_q;
  logic               neg_r_q;
  logic               div0_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign accept    = (state_q == IDLE) && start && !flush && is_multi(op);
  assign mt_wr     = (state_q == IDLE) && start && !flush && ((op == MD_MTHI) || (op == MD_MTLO));
  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .resetn (resetn),
    .load   (accept),
    .step   ((state_q == RUN) && !flush),
    .is_div ((op == MD_DIV) || (op == MD_DIVU)),
    .op_a   (a_mag),
    .op_b   (b_mag),
    .acc    (core_acc),
    .last   (core_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (core_last) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Sign flags are decided at accept; the core only ever sees magnitudes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      div0_q  <= 1'b0;
      a_q     <= '0;
    end else if (accept) begin
      div_q   <= (op == MD_DIV) || (op == MD_DIVU);
      neg_q   <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r_q <= signed_op && a[WIDTH-1];
      div0_q  <= (b == '0);
      a_q     <= a;
    end
  end

  always_comb begin
    fix_hi = '0;
    fix_lo = '0;
    if (!div_q) begin
      {fix_hi, fix_lo} = neg_q ? -core_acc : core_acc;
    end else if (div0_q) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else begin
      fix_lo = neg_q   ? -core_acc[WIDTH-1:0]       : core_acc[WIDTH-1:0];
      fix_hi = neg_r_q ? -core_acc[2*WIDTH-1:WIDTH] : core_acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (mt_wr) begin
      if (op == MD_MTHI) hi_q <= a;
      else               lo_q <= a;
    end else if ((state_q == FIX) && !flush) begin
      hi_q <= fix_hi;
      lo_q <= fix_lo;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIX) && !flush;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule
